aes_encrypt_iter: RTL and testbench

//   Iterative AES forward cipher: the encryption counterpart of the unrolled inverse-round decrypt chain.

---
 rtl/aes_encrypt_iter.sv | 140 ++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES forward cipher, one full round per clock
// Byte 0 of text_in/round_key/text_out is bits [127:120]; bytes are column-major.
module aes_encrypt_iter #(
  parameter int NR = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] text_in,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] text_out
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  localparam logic [3:0] LAST_MID_RND = 4'(NR - 1);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // SubBytes then ShiftRows: output byte (row r, col c) comes from input (row r, col c+r).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = sbox(s[127-8*(4*((c+row)%4)+row) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] text_out_q, text_out_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] sb_sr, mc;

  assign sb_sr = sub_shift(st_q);
  assign mc    = mix_columns(sb_sr);

  // Handshake and key index decode purely from state/round so the key store sees them early.
  assign in_ready  = (state_q == IDLE);
  assign key_idx   = (state_q == ROUND || state_q == FINAL) ? rnd_q : 4'd0;
  assign out_valid = out_valid_q;
  assign text_out  = text_out_q;

  // State, round counter, cipher state and output registers; reset discards any in-flight block.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      st_q        <= '0;
      text_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      st_q        <= st_d;
      text_out_q  <= text_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: initial whitening on accept, NR-1 full rounds, a final round without MixColumns.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    st_d        = st_q;
    text_out_d  = text_out_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = text_in ^ round_key;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d  = mc ^ round_key;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_MID_RND) state_d = FINAL;
      end
      FINAL: begin
        text_out_d  = sb_sr ^ round_key;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rnd_d       = 4'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - directed-vector bench for aes_encrypt_iter (NR=10 and NR=14 builds)
module tb_aes_encrypt_iter;

  logic         Clk = 1'b0;
  logic         Reset, in_valid, out_ready;
  logic [127:0] text_in;
  logic         in_ready10, out_valid10, in_ready14, out_valid14;
  logic [3:0]   key_idx10, key_idx14;
  logic [127:0] round_key10, round_key14, text_out10, text_out14;

  logic [127:0] rk10 [16];
  logic [127:0] rk14 [16];
  logic [31:0]  w [60];
  logic [7:0]   sb [256];

  bit           sel14;
  logic         s_ready, s_valid;
  logic [3:0]   s_kidx;
  logic [127:0] s_tout;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  assign round_key10 = rk10[key_idx10];
  assign round_key14 = rk14[key_idx14];

  assign s_ready = sel14 ? in_ready14  : in_ready10;
  assign s_valid = sel14 ? out_valid14 : out_valid10;
  assign s_kidx  = sel14 ? key_idx14   : key_idx10;
  assign s_tout  = sel14 ? text_out14  : text_out10;

  aes_encrypt_iter #(.NR(10)) dut10 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready10),
    .text_in(text_in), .key_idx(key_idx10), .round_key(round_key10),
    .out_valid(out_valid10), .out_ready(out_ready), .text_out(text_out10)
  );

  aes_encrypt_iter #(.NR(14)) dut14 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready14),
    .text_in(text_in), .key_idx(key_idx14), .round_key(round_key14),
    .out_valid(out_valid14), .out_ready(out_ready), .text_out(text_out14)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from the multiplicative inverse plus affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit to14);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (to14) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else      rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  function automatic logic [127:0] rk_get(input int nr, input int r);
    return (nr == 14) ? rk14[r] : rk10[r];
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k, o;
    k = rk_get(nr, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = gmul(8'h02, s[4*c]) ^ gmul(8'h03, s[4*c+1]) ^ s[4*c+2] ^ s[4*c+3];
          t[4*c+1] = s[4*c] ^ gmul(8'h02, s[4*c+1]) ^ gmul(8'h03, s[4*c+2]) ^ s[4*c+3];
          t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(8'h02, s[4*c+2]) ^ gmul(8'h03, s[4*c+3]);
          t[4*c+3] = gmul(8'h03, s[4*c]) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(8'h02, s[4*c+3]);
        end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      k = rk_get(nr, r);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the selected DUT idle. lat counts rising edges from the
  // accept edge (counted as 1) through the edge that raises out_valid.
  task automatic run_block(input logic [127:0] pt, input int budget,
                           output logic [127:0] ct, output int lat, output bit keys_ok);
    keys_ok  = (s_kidx == 4'd0);
    in_valid = 1'b1;
    text_in  = pt;
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
    text_in  = ~pt;
    lat = 1;
    while (!s_valid && lat < budget) begin
      if (s_kidx != 4'(lat)) keys_ok = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      lat++;
    end
    ct = s_tout;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt [3];
    logic [127:0] ct, pt2;
    logic [127:0] pts [4];
    logic [127:0] exps [4];
    int           acc_t [4];
    int           lat, n, n_acc, n_out;
    bit           keys_ok, stable;

    vt[0] = '{"appB",  KEY_B,  PT_B,  CT_B};
    vt[1] = '{"appC1", KEY_C1, PT_C,  CT_C1};
    vt[2] = '{"zero",  128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; text_in = '0; sel14 = 1'b0;
    for (int i = 0; i < 16; i++) begin rk10[i] = '0; rk14[i] = '0; end
    build_sbox();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    // reset state of both builds
    chk("rst_in_ready10",  128'(in_ready10),  128'd1);
    chk("rst_out_valid10", 128'(out_valid10), 128'd0);
    chk("rst_text_out10",  text_out10,        128'd0);
    chk("rst_key_idx10",   128'(key_idx10),   128'd0);
    chk("rst_in_ready14",  128'(in_ready14),  128'd1);
    chk("rst_out_valid14", 128'(out_valid14), 128'd0);
    chk("rst_text_out14",  text_out14,        128'd0);

    // known-answer table, NR=10
    for (int i = 0; i < 3; i++) begin
      expand({vt[i].key, 128'h0}, 4, 10, 1'b0);
      run_block(vt[i].pt, 30, ct, lat, keys_ok);
      chk({vt[i].name, "_ct"},   ct,            vt[i].ct);
      chk({vt[i].name, "_lat"},  128'(lat),     128'd11);
      chk({vt[i].name, "_kidx"}, 128'(keys_ok), 128'd1);
      release_out();
      chk({vt[i].name, "_idle"}, 128'({in_ready10, out_valid10}), 128'b10);
    end

    // backpressure: result held, second block refused until out_ready pulses
    expand({KEY_C1, 128'h0}, 4, 10, 1'b0);
    run_block(PT_C, 30, ct, lat, keys_ok);
    chk("bp_ct", ct, CT_C1);
    pt2      = 128'hfedcba98765432100123456789abcdef;
    in_valid = 1'b1;
    text_in  = pt2;
    stable   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (!out_valid10 || text_out10 !== CT_C1 || in_ready10) stable = 1'b0;
    end
    chk("bp_hold", 128'(stable), 128'd1);
    out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    out_ready = 1'b0;
    chk("bp_release", 128'({in_ready10, out_valid10}), 128'b10);
    run_block(pt2, 30, ct, lat, keys_ok);
    chk("bp_second_ct",  ct,        model_enc(pt2, 10));
    chk("bp_second_lat", 128'(lat), 128'd11);
    release_out();

    // reset in the middle of an App. B block
    expand({KEY_B, 128'h0}, 4, 10, 1'b0);
    in_valid = 1'b1;
    text_in  = PT_B;
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
    n = 0;
    while (key_idx10 != 4'd5 && n < 20) begin
      @(posedge Clk);
      @(negedge Clk);
      n++;
    end
    chk("mid_reached_rnd5", 128'(key_idx10), 128'd5);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("mid_in_ready",  128'(in_ready10),  128'd1);
    chk("mid_out_valid", 128'(out_valid10), 128'd0);
    chk("mid_text_out",  text_out10,        128'd0);
    expand({KEY_C1, 128'h0}, 4, 10, 1'b0);
    run_block(PT_C, 30, ct, lat, keys_ok);
    chk("mid_after_ct",  ct,        CT_C1);
    chk("mid_after_lat", 128'(lat), 128'd11);
    release_out();

    // back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 4; i++) begin
      pts[i]  = {$urandom, $urandom, $urandom, $urandom};
      exps[i] = model_enc(pts[i], 10);
      acc_t[i] = 0;
    end
    n_acc = 0;
    n_out = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && n_out < 4; k++) begin
      @(negedge Clk);
      if (n_acc < 4) begin in_valid = 1'b1; text_in = pts[n_acc]; end
      else in_valid = 1'b0;
      if (out_valid10) begin
        if (n_out < 4) chk($sformatf("b2b_ct%0d", n_out), text_out10, exps[n_out]);
        n_out++;
      end
      if (in_ready10 && in_valid && n_acc < 4) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
    end
    chk("b2b_count", 128'(n_out), 128'd4);
    // accept edges NR+2 apart: each block spans NR+3 cycles counting both accept cycles
    for (int i = 1; i < 4; i++)
      chk($sformatf("b2b_spacing%0d", i), 128'(acc_t[i] - acc_t[i-1]), 128'd12);
    @(posedge Clk);
    @(negedge Clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    // NR=14 build with the AES-256 key
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    sel14 = 1'b1;
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 1'b1);
    run_block(PT_C, 40, ct, lat, keys_ok);
    chk("nr14_ct",   ct,            128'h8ea2b7ca516745bfeafc49904b496089);
    chk("nr14_lat",  128'(lat),     128'd15);
    chk("nr14_kidx", 128'(keys_ok), 128'd1);
    release_out();
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    run_block(pt2, 40, ct, lat, keys_ok);
    chk("nr14_rand_ct", ct, model_enc(pt2, 14));
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
